multi_button_handler: RTL and testbench
=======================================

Name: multi_button_handler

Overview:
Parametrised successor to the single-button debounce/edge block. It debounces N independent push-buttons and synchronises each one to clk. Per channel it produces one-cycle press, release, long-press and auto-repeat pulses, gated by the top-level main_state. It sits between board pins and the main control FSM; sector-group change, menu stepping and similar actions consume its pulses.

Parameters:
N_BTN, 4, number of button channels
DEBOUNCE_PERIOD, 250000, stable cycles required before accepting a level (10 ms at 25 MHz)
LONG_PRESS, 12500000, cycles held after acceptance before long_pulse fires (0.5 s)
REPEAT_PERIOD, 2500000, cycles between repeat_pulse while held past long-press; 0 disables repeat
CNT_W, 24, width of all internal counters; must hold max(DEBOUNCE_PERIOD, LONG_PRESS, REPEAT_PERIOD)
STATE_W, 2, width of main_state
ENABLE_STATE, 2'b10, main_state value in which pulses are emitted (DONE)
GATE_EN, 1, 1 = gate pulses by main_state; 0 = always emit
ACTIVE_LOW, 0, 1 = invert btn_in (pressed = 0)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_in  in  N_BTN  raw asynchronous button pins
main_state  in  STATE_W  top-level FSM state
btn_level  out  N_BTN  debounced level (ungated)
press_pulse  out  N_BTN  1-cycle pulse on accepted press
release_pulse  out  N_BTN  1-cycle pulse on accepted release
long_pulse  out  N_BTN  1-cycle pulse at long-press threshold
repeat_pulse  out  N_BTN  1-cycle pulse every REPEAT_PERIOD after long-press
any_pressed  out  1  OR of btn_level

Behaviour:
- Reset (async) clears the synchronisers, candidate, stable level, all counters and every output to 0, and forces all FSMs to IDLE. Reset mid-press produces no pulses on deassertion. After release of reset, a button already held is accepted as a fresh press after the normal latency.
- Per channel: btn_in goes XOR ACTIVE_LOW, then a 2-FF synchroniser (s1, s2).
- Debounce: if s2 != candidate, candidate <= s2 and dcnt <= 0. Else if dcnt < DEBOUNCE_PERIOD, dcnt++. Else stable <= candidate.
- Latency: btn_in rises and is held. Edge 1 sets s1, edge 2 sets s2, edge 3 loads candidate, edge 3+P reaches dcnt = P, and edge 4+P sets btn_level = 1. press_pulse is high for the cycle after edge 5+P.
- Any glitch shorter than DEBOUNCE_PERIOD+1 cycles is never accepted.
- FSM states are IDLE, PRESSED and HELD. All pulse outputs are registered.
  - IDLE: on a stable rise, go to PRESSED with hcnt <= 0 and raise press.
  - PRESSED: hcnt++. When hcnt == LONG_PRESS-1, raise long, go to HELD, rcnt <= 0.
  - HELD: if REPEAT_PERIOD != 0, rcnt++. When rcnt == REPEAT_PERIOD-1, raise repeat and set rcnt <= 0.
  - PRESSED or HELD: a stable fall raises release and returns to IDLE. This has priority over a simultaneous long/repeat threshold, which is then suppressed.
- Gating: when GATE_EN = 1 and main_state != ENABLE_STATE, all four pulse types are forced to 0. The FSM still advances, so pulses are lost, not deferred. btn_level and any_pressed are never gated.
- Channels are fully independent; simultaneous presses give simultaneous pulses.
- Counters never wrap; they stop at their threshold compare.

Decomposition:
- Package btn_pkg holds the FSM state enum (IDLE, PRESSED, HELD) and the main_state DONE encoding constant.
- Sub-module btn_channel contains one synchroniser, debounce and FSM. The top instantiates N_BTN copies in a generate loop, then applies gating and any_pressed.

Test Plan:
Bench parameters: N_BTN=4, DEBOUNCE_PERIOD=4, LONG_PRESS=20, REPEAT_PERIOD=8, main_state=2'b10.
1. btn_in[0] high for 3 cycles then low -> no btn_level change, no pulses on any channel.
2. btn_in[1] held high for 40 cycles -> btn_level[1] sets at edge 8, press at edge 9, long 20 cycles later, then repeat every 8 cycles. On btn_in low, one release_pulse[1] appears after 9 cycles.
3. btn_in[2] high for 15 accepted cycles -> exactly one press and one release, no long_pulse.
4. main_state=2'b00 during a 60-cycle press on channel 3 -> btn_level[3] and any_pressed high, all pulses 0. Switching main_state to 2'b10 mid-hold -> subsequent repeat pulses appear.
5. Channels 0 and 1 pressed on the same cycle -> press_pulse = 4'b0011 in one cycle.
6. Assert reset during HELD on channel 1 -> outputs 0 immediately without a clock edge. After reset with the button still held -> a fresh press_pulse follows 9 cycles later.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the multi-channel push-button handler.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    // main_state encoding in which button pulses are allowed out
    localparam logic [1:0] MAIN_DONE = 2'b10;

endpackage : btn_pkg

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, counter debounce and press/long/repeat FSM.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_PERIOD = 250000,
    parameter int unsigned LONG_PRESS      = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000,
    parameter int unsigned CNT_W           = 24,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic pulse_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_PERIOD);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    logic             s1;
    logic             s2;
    logic             candidate;
    logic             stable;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] rcnt;
    btn_state_t       state;

    // Polarity normalisation and metastability filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw ^ ACTIVE_LOW;
            s2 <= s1;
        end
    end

    // A level is accepted only after it has been seen unchanged DEBOUNCE_PERIOD+1 times
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate <= 1'b0;
            dcnt      <= '0;
            stable    <= 1'b0;
        end else if (s2 != candidate) begin
            candidate <= s2;
            dcnt      <= '0;
        end else if (dcnt < DEB_MAX) begin
            dcnt <= dcnt + CNT_W'(1);
        end else begin
            stable <= candidate;
        end
    end

    assign level = stable;

    // Press / long-press / auto-repeat FSM; release beats any coincident threshold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hcnt          <= '0;
            rcnt          <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (stable) begin
                        state       <= PRESSED;
                        hcnt        <= '0;
                        press_pulse <= pulse_en;
                    end
                end
                PRESSED: begin
                    if (!stable) begin
                        state         <= IDLE;
                        release_pulse <= pulse_en;
                    end else if (hcnt == LONG_LAST) begin
                        state      <= HELD;
                        rcnt       <= '0;
                        long_pulse <= pulse_en;
                    end else begin
                        hcnt <= hcnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!stable) begin
                        state         <= IDLE;
                        release_pulse <= pulse_en;
                    end else if (REPEAT_PERIOD != 0) begin
                        if (rcnt == REP_LAST) begin
                            rcnt         <= '0;
                            repeat_pulse <= pulse_en;
                        end else begin
                            rcnt <= rcnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : btn_channel

// File: rtl/multi_button_handler.sv
// N-channel debounced button handler with state-gated press/release/long/repeat pulses.
module multi_button_handler
    import btn_pkg::*;
#(
    parameter int unsigned         N_BTN           = 4,
    parameter int unsigned         DEBOUNCE_PERIOD = 250000,
    parameter int unsigned         LONG_PRESS      = 12500000,
    parameter int unsigned         REPEAT_PERIOD   = 2500000,
    parameter int unsigned         CNT_W           = 24,
    parameter int unsigned         STATE_W         = 2,
    parameter logic [STATE_W-1:0]  ENABLE_STATE    = STATE_W'(MAIN_DONE),
    parameter bit                  GATE_EN         = 1'b1,
    parameter bit                  ACTIVE_LOW      = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_BTN-1:0]   btn_in,
    input  logic [STATE_W-1:0] main_state,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   press_pulse,
    output logic [N_BTN-1:0]   release_pulse,
    output logic [N_BTN-1:0]   long_pulse,
    output logic [N_BTN-1:0]   repeat_pulse,
    output logic               any_pressed
);

    // Gating is folded into each channel's pulse registers so outputs stay flopped
    logic pulse_en;
    assign pulse_en = !GATE_EN || (main_state == ENABLE_STATE);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_PERIOD (DEBOUNCE_PERIOD),
            .LONG_PRESS      (LONG_PRESS),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .btn_raw       (btn_in[i]),
            .pulse_en      (pulse_en),
            .level         (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

    assign any_pressed = |btn_level;

endmodule : multi_button_handler

// File: tb/tb_multi_button_handler.sv
// Directed bench for multi_button_handler with short debounce/long/repeat periods.
module tb_multi_button_handler;

    logic       clk;
    logic       reset;
    logic [3:0] btn_in;
    logic [1:0] main_state;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_pulse;
    logic [3:0] repeat_pulse;
    logic       any_pressed;

    int checks = 0;
    int errors = 0;

    multi_button_handler #(
        .N_BTN           (4),
        .DEBOUNCE_PERIOD (4),
        .LONG_PRESS      (20),
        .REPEAT_PERIOD   (8),
        .CNT_W           (24),
        .STATE_W         (2),
        .ENABLE_STATE    (2'b10),
        .GATE_EN         (1'b1),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .main_state    (main_state),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .any_pressed   (any_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        btn_in     = 4'b0000;
        main_state = 2'b10;
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state got %b_%b_%b_%b_%b_%b exp all zero",
                     btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed);
        end
        step();
        step();
        #1 reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed} !== 21'd0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got %b_%b_%b_%b_%b_%b exp all zero", k,
                         btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed);
            end
        end
    endtask

    // 3-cycle glitch on channel 0 must be rejected
    task automatic test_glitch();
        btn_in = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            if (k == 4) btn_in = 4'b0000;
            step();
            checks++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed} !== 21'd0) begin
                errors++;
                $display("FAIL glitch k=%0d got %b_%b_%b_%b_%b_%b exp all zero", k,
                         btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed);
            end
        end
    endtask

    // Channel 1 held through long-press and two repeats, then released
    task automatic test_hold();
        logic [3:0] e_lvl, e_prs, e_rel, e_lng, e_rep;
        btn_in = 4'b0010;
        for (int k = 1; k <= 56; k++) begin
            if (k == 41) btn_in = 4'b0000;
            step();
            e_lvl = (k >= 8 && k < 48)     ? 4'b0010 : 4'b0000;
            e_prs = (k == 9)               ? 4'b0010 : 4'b0000;
            e_lng = (k == 29)              ? 4'b0010 : 4'b0000;
            e_rep = (k == 37 || k == 45)   ? 4'b0010 : 4'b0000;
            e_rel = (k == 49)              ? 4'b0010 : 4'b0000;
            checks++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed} !==
                {e_lvl, e_prs, e_rel, e_lng, e_rep, |e_lvl}) begin
                errors++;
                $display("FAIL hold k=%0d lvl/prs/rel/lng/rep/any got %b_%b_%b_%b_%b_%b exp %b_%b_%b_%b_%b_%b", k,
                         btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed,
                         e_lvl, e_prs, e_rel, e_lng, e_rep, |e_lvl);
            end
        end
    endtask

    // Channel 2 accepted for 15 cycles: press and release only
    task automatic test_short_press();
        logic [3:0] e_lvl, e_prs, e_rel;
        btn_in = 4'b0100;
        for (int k = 1; k <= 30; k++) begin
            if (k == 16) btn_in = 4'b0000;
            step();
            e_lvl = (k >= 8 && k < 23) ? 4'b0100 : 4'b0000;
            e_prs = (k == 9)           ? 4'b0100 : 4'b0000;
            e_rel = (k == 24)          ? 4'b0100 : 4'b0000;
            checks++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed} !==
                {e_lvl, e_prs, e_rel, 4'b0000, 4'b0000, |e_lvl}) begin
                errors++;
                $display("FAIL short_press k=%0d lvl/prs/rel/lng/rep/any got %b_%b_%b_%b_%b_%b exp %b_%b_%b_0000_0000_%b", k,
                         btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed,
                         e_lvl, e_prs, e_rel, |e_lvl);
            end
        end
    endtask

    // Channel 3 pressed while gated; enable mid-hold; release wins over coincident repeat
    task automatic test_gating();
        logic [3:0] e_lvl, e_rel, e_rep;
        main_state = 2'b00;
        btn_in     = 4'b1000;
        for (int k = 1; k <= 76; k++) begin
            if (k == 50) main_state = 2'b10;
            if (k == 61) btn_in = 4'b0000;
            step();
            e_lvl = (k >= 8 && k < 68)     ? 4'b1000 : 4'b0000;
            e_rep = (k == 53 || k == 61)   ? 4'b1000 : 4'b0000;
            e_rel = (k == 69)              ? 4'b1000 : 4'b0000;
            checks++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed} !==
                {e_lvl, 4'b0000, e_rel, 4'b0000, e_rep, |e_lvl}) begin
                errors++;
                $display("FAIL gating k=%0d lvl/prs/rel/lng/rep/any got %b_%b_%b_%b_%b_%b exp %b_0000_%b_0000_%b_%b", k,
                         btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed,
                         e_lvl, e_rel, e_rep, |e_lvl);
            end
        end
    endtask

    // Channels 0 and 1 pressed together
    task automatic test_simultaneous();
        logic [3:0] e_lvl, e_prs, e_rel;
        btn_in = 4'b0011;
        for (int k = 1; k <= 26; k++) begin
            if (k == 13) btn_in = 4'b0000;
            step();
            e_lvl = (k >= 8 && k < 20) ? 4'b0011 : 4'b0000;
            e_prs = (k == 9)           ? 4'b0011 : 4'b0000;
            e_rel = (k == 21)          ? 4'b0011 : 4'b0000;
            checks++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed} !==
                {e_lvl, e_prs, e_rel, 4'b0000, 4'b0000, |e_lvl}) begin
                errors++;
                $display("FAIL simultaneous k=%0d lvl/prs/rel/lng/rep/any got %b_%b_%b_%b_%b_%b exp %b_%b_%b_0000_0000_%b", k,
                         btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed,
                         e_lvl, e_prs, e_rel, |e_lvl);
            end
        end
    endtask

    // Reset while channel 1 is HELD; held button re-accepted as a fresh press
    task automatic test_reset_mid_hold();
        logic [3:0] e_lvl, e_prs, e_rel, e_lng;
        btn_in = 4'b0010;
        for (int k = 1; k <= 32; k++) begin
            step();
            e_lvl = (k >= 8)   ? 4'b0010 : 4'b0000;
            e_prs = (k == 9)   ? 4'b0010 : 4'b0000;
            e_lng = (k == 29)  ? 4'b0010 : 4'b0000;
            checks++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed} !==
                {e_lvl, e_prs, 4'b0000, e_lng, 4'b0000, |e_lvl}) begin
                errors++;
                $display("FAIL pre_reset k=%0d lvl/prs/rel/lng/rep/any got %b_%b_%b_%b_%b_%b exp %b_%b_0000_%b_0000_%b", k,
                         btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed,
                         e_lvl, e_prs, e_lng, |e_lvl);
            end
        end
        reset = 1'b1;
        #2;
        checks++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset got %b_%b_%b_%b_%b_%b exp all zero",
                     btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed);
        end
        reset = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            if (k == 13) btn_in = 4'b0000;
            step();
            e_lvl = (k >= 8 && k < 20) ? 4'b0010 : 4'b0000;
            e_prs = (k == 9)           ? 4'b0010 : 4'b0000;
            e_rel = (k == 21)          ? 4'b0010 : 4'b0000;
            checks++;
            if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed} !==
                {e_lvl, e_prs, e_rel, 4'b0000, 4'b0000, |e_lvl}) begin
                errors++;
                $display("FAIL post_reset k=%0d lvl/prs/rel/lng/rep/any got %b_%b_%b_%b_%b_%b exp %b_%b_%b_0000_0000_%b", k,
                         btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_pressed,
                         e_lvl, e_prs, e_rel, |e_lvl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_hold();
        test_short_press();
        test_gating();
        test_simultaneous();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_multi_button_handler
